adder_pipe: RTL and testbench

ADDER_PIPE -- requirements
Module: adder_pipe

---
 rtl/adder_pipe_if.sv | 36 +++
 rtl/adder_pipe.sv | 136 +++++++++++++
 tb/tb_adder_pipe.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/adder_pipe_if.sv
// Handshake bundle for adder_pipe: operand request channel and sum response channel.
// The overflow signal exists only when ADDER_OVERFLOW_EN is defined.
interface adder_pipe_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] ina;
  logic [WIDTH-1:0] inb;
  logic             carry_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum_out;
  logic             carry_out;
`ifdef ADDER_OVERFLOW_EN
  logic             overflow;
`endif

  // Source of operands and consumer of results
  modport master (
    output in_valid, ina, inb, carry_in, out_ready,
    input  in_ready, out_valid, sum_out, carry_out
`ifdef ADDER_OVERFLOW_EN
    , input overflow
`endif
  );

  // The adder pipeline itself
  modport slave (
    input  in_valid, ina, inb, carry_in, out_ready,
    output in_ready, out_valid, sum_out, carry_out
`ifdef ADDER_OVERFLOW_EN
    , output overflow
`endif
  );
endinterface

// File: rtl/adder_pipe.sv
// Pipelined ripple adder: STAGE_W bits per stage, valid/ready flow control with full-pipeline stall.
// Optional signed overflow output is enabled by defining ADDER_OVERFLOW_EN.
module adder_pipe #(
  parameter int WIDTH   = 16,
  parameter int STAGE_W = 4
) (
  input logic         clk,
  input logic         rst,
  adder_pipe_if.slave bus
);
  localparam int STAGES = (STAGE_W < 1) ? 1 : WIDTH / STAGE_W;
  localparam int LAST   = STAGES - 1;
  localparam int MSB    = WIDTH - 1;

  generate
    if (STAGE_W < 1) begin : g_bad_stage_w
      $error("adder_pipe: STAGE_W must be at least 1");
    end else if ((WIDTH % STAGE_W) != 0) begin : g_bad_width
      $error("adder_pipe: WIDTH must be a multiple of STAGE_W");
    end
  endgenerate

  // Per-stage registers: partial sum, carry, remaining operand slices, valid
  logic [WIDTH-1:0]  r_a   [STAGES];
  logic [WIDTH-1:0]  r_b   [STAGES];
  logic [WIDTH-1:0]  r_sum [STAGES];
  logic [STAGES-1:0] r_c;
  logic [STAGES-1:0] r_v;

  // Stage inputs and next-state values
  logic [WIDTH-1:0]   w_a_in  [STAGES];
  logic [WIDTH-1:0]   w_b_in  [STAGES];
  logic [WIDTH-1:0]   w_s_in  [STAGES];
  logic [STAGES-1:0]  w_c_in;
  logic [STAGES-1:0]  w_v_in;
  logic [STAGE_W:0]   w_part  [STAGES];
  logic [WIDTH-1:0]   w_a_nx  [STAGES];
  logic [WIDTH-1:0]   w_b_nx  [STAGES];
  logic [WIDTH-1:0]   w_s_nx  [STAGES];
  logic               w_stall;

  assign w_stall      = r_v[LAST] && !bus.out_ready;
  assign bus.in_ready = !w_stall;

  // Slice addition for every stage; consumed operand slices are cleared
  always_comb begin
    w_a_in = '{default: '0};
    w_b_in = '{default: '0};
    w_s_in = '{default: '0};
    w_part = '{default: '0};
    w_a_nx = '{default: '0};
    w_b_nx = '{default: '0};
    w_s_nx = '{default: '0};
    w_c_in = '0;
    w_v_in = '0;
    for (int k = 0; k < STAGES; k++) begin
      if (k == 0) begin
        w_a_in[k] = bus.ina;
        w_b_in[k] = bus.inb;
        w_s_in[k] = '0;
        w_c_in[k] = bus.carry_in;
        w_v_in[k] = bus.in_valid;
      end else begin
        w_a_in[k] = r_a[k-1];
        w_b_in[k] = r_b[k-1];
        w_s_in[k] = r_sum[k-1];
        w_c_in[k] = r_c[k-1];
        w_v_in[k] = r_v[k-1];
      end
      w_part[k] = {1'b0, w_a_in[k][k*STAGE_W +: STAGE_W]}
                + {1'b0, w_b_in[k][k*STAGE_W +: STAGE_W]}
                + {{STAGE_W{1'b0}}, w_c_in[k]};
      w_s_nx[k] = w_s_in[k];
      w_s_nx[k][k*STAGE_W +: STAGE_W] = w_part[k][STAGE_W-1:0];
      w_a_nx[k] = w_a_in[k];
      w_a_nx[k][k*STAGE_W +: STAGE_W] = {STAGE_W{1'b0}};
      w_b_nx[k] = w_b_in[k];
      w_b_nx[k][k*STAGE_W +: STAGE_W] = {STAGE_W{1'b0}};
    end
  end

  // Pipeline advance: everything holds while the output is stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        r_a[k]   <= '0;
        r_b[k]   <= '0;
        r_sum[k] <= '0;
        r_c[k]   <= 1'b0;
        r_v[k]   <= 1'b0;
      end
    end else if (!w_stall) begin
      for (int k = 0; k < STAGES; k++) begin
        r_a[k]   <= w_a_nx[k];
        r_b[k]   <= w_b_nx[k];
        r_sum[k] <= w_s_nx[k];
        r_c[k]   <= w_part[k][STAGE_W];
        r_v[k]   <= w_v_in[k];
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        r_a[k]   <= r_a[k];
        r_b[k]   <= r_b[k];
        r_sum[k] <= r_sum[k];
        r_c[k]   <= r_c[k];
        r_v[k]   <= r_v[k];
      end
    end
  end

  assign bus.out_valid = r_v[LAST];
  assign bus.sum_out   = r_sum[LAST];
  assign bus.carry_out = r_c[LAST];

`ifdef ADDER_OVERFLOW_EN
  logic r_ov;
  logic w_ov_nx;

  // The sign bits are still present at the last stage input, where the top slice is added
  assign w_ov_nx = (w_a_in[LAST][MSB] == w_b_in[LAST][MSB]) &&
                   (w_s_nx[LAST][MSB] != w_a_in[LAST][MSB]);

  // Overflow register aligned with the last stage
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ov <= 1'b0;
    end else if (!w_stall) begin
      r_ov <= w_ov_nx;
    end else begin
      r_ov <= r_ov;
    end
  end

  assign bus.overflow = r_ov;
`endif
endmodule

// File: tb/tb_adder_pipe.sv
// Self-checking bench for adder_pipe: directed vectors, stall/reset sequences, random traffic vs model.
module tb_adder_pipe;
  localparam int W    = 16;
  localparam int ST   = 4;
  localparam int NOPS = 10000;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] s;
    logic         c;
    logic         ov;
  } vec_t;

  logic clk;
  logic rst;
  adder_pipe_if #(.WIDTH(W)) bus ();
  adder_pipe #(.WIDTH(W), .STAGE_W(ST)) dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_errors = 0;
  vec_t vecs [8];
  vec_t q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    bus.in_valid = 1'b1;
    bus.ina      = a;
    bus.inb      = b;
    bus.carry_in = cin;
  endtask

  function automatic vec_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    vec_t        v;
    logic [W:0]  full;
    full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    v.a  = a;
    v.b  = b;
    v.cin = cin;
    v.s  = full[W-1:0];
    v.c  = full[W];
    v.ov = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
    return v;
  endfunction

  initial begin
    vec_t exp_v;
    int   got;
    int   sent;
    int   cyc;
    bit   pend;
    bit   was_stall;
    logic [W-1:0] last_s;
    logic last_c;

    vecs[0] = '{16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[3] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};
    vecs[4] = '{16'h000F, 16'h0001, 1'b0, 16'h0010, 1'b0, 1'b0};
    vecs[5] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
    vecs[6] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[7] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};

    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.ina = '0;
    bus.inb = '0;
    bus.carry_in = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    tick();
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_sum", 32'(bus.sum_out), 32'd0);
    chk("rst_carry", 32'(bus.carry_out), 32'd0);
`ifdef ADDER_OVERFLOW_EN
    chk("rst_overflow", 32'(bus.overflow), 32'd0);
`endif
    rst = 1'b0;
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    tick();

    // Single operations: exact latency and result per vector
    for (int i = 0; i < 8; i++) begin
      offer(vecs[i].a, vecs[i].b, vecs[i].cin);
      #1;
      chk("vec_in_ready", 32'(bus.in_ready), 32'd1);
      tick();
      bus.in_valid = 1'b0;
      for (int j = 1; j <= ST - 1; j++) begin
        if (j < ST - 1) begin
          tick();
          chk("vec_early_valid", 32'(bus.out_valid), 32'd0);
        end else begin
          tick();
          chk("vec_valid", 32'(bus.out_valid), 32'd1);
          chk("vec_sum", 32'(bus.sum_out), 32'(vecs[i].s));
          chk("vec_carry", 32'(bus.carry_out), 32'(vecs[i].c));
`ifdef ADDER_OVERFLOW_EN
          chk("vec_overflow", 32'(bus.overflow), 32'(vecs[i].ov));
`endif
        end
      end
      tick();
      chk("vec_drained", 32'(bus.out_valid), 32'd0);
    end

    // Back-to-back with a three-cycle output stall
    offer(16'h0101, 16'h0101, 1'b0);
    tick();
    offer(16'h1000, 16'h1000, 1'b0);
    tick();
    offer(16'h8000, 16'h8000, 1'b0);
    tick();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("stall_valid", 32'(bus.out_valid), 32'd1);
      chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
      chk("stall_sum_hold", 32'(bus.sum_out), 32'h0202);
      chk("stall_carry_hold", 32'(bus.carry_out), 32'd0);
      if (i < 2) tick();
    end
    bus.out_ready = 1'b1;
    #1;
    chk("unstall_in_ready", 32'(bus.in_ready), 32'd1);
    chk("seq_sum0", 32'(bus.sum_out), 32'h0202);
    tick();
    chk("seq_valid1", 32'(bus.out_valid), 32'd1);
    chk("seq_sum1", 32'(bus.sum_out), 32'h2000);
    chk("seq_carry1", 32'(bus.carry_out), 32'd0);
    tick();
    chk("seq_valid2", 32'(bus.out_valid), 32'd1);
    chk("seq_sum2", 32'(bus.sum_out), 32'h0000);
    chk("seq_carry2", 32'(bus.carry_out), 32'd1);
    tick();
    chk("seq_drained", 32'(bus.out_valid), 32'd0);

    // Reset with two operations in flight and one offered during reset
    offer(16'h1111, 16'h2222, 1'b0);
    tick();
    offer(16'h3333, 16'h4444, 1'b1);
    tick();
    offer(16'hAAAA, 16'h5555, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("midrst_sum", 32'(bus.sum_out), 32'd0);
    chk("midrst_carry", 32'(bus.carry_out), 32'd0);
    for (int i = 0; i < 8; i++) begin
      chk("midrst_no_out", 32'(bus.out_valid), 32'd0);
      tick();
    end

    // Random traffic against the queue model
    got = 0;
    sent = 0;
    cyc = 0;
    pend = 1'b0;
    was_stall = 1'b0;
    last_s = '0;
    last_c = 1'b0;
    while (got < NOPS && cyc < 60000) begin
      if (!pend && sent < NOPS && $urandom_range(0, 3) != 0) begin
        offer(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
        pend = 1'b1;
      end else if (!pend) begin
        bus.in_valid = 1'b0;
      end
      bus.out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (was_stall) begin
        chk("rnd_hold_valid", 32'(bus.out_valid), 32'd1);
        chk("rnd_hold_sum", 32'(bus.sum_out), 32'(last_s));
        chk("rnd_hold_carry", 32'(bus.carry_out), 32'(last_c));
      end
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) begin
          chk("rnd_unexpected_out", 32'd1, 32'd0);
        end else begin
          exp_v = q.pop_front();
          chk("rnd_sum", 32'(bus.sum_out), 32'(exp_v.s));
          chk("rnd_carry", 32'(bus.carry_out), 32'(exp_v.c));
`ifdef ADDER_OVERFLOW_EN
          chk("rnd_overflow", 32'(bus.overflow), 32'(exp_v.ov));
`endif
        end
        got++;
      end
      if (bus.in_valid && bus.in_ready) begin
        q.push_back(model(bus.ina, bus.inb, bus.carry_in));
        sent++;
        pend = 1'b0;
      end
      was_stall = bus.out_valid && !bus.out_ready;
      last_s = bus.sum_out;
      last_c = bus.carry_out;
      tick();
      cyc++;
    end
    chk("rnd_result_count", 32'(got), 32'(NOPS));
    chk("rnd_queue_empty", 32'(q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
